wishbone_to_axi4lite: RTL and testbench

Bridge from a Wishbone classic slave port to an AXI4-Lite master port, the reverse of the AXI4-Lite-to-Wishbone path used in front of peripherals. Lets a Wishbone-side CPU or DMA reach AXI4-Lite peripherals. One transaction is in flight at a time. Request fields are registered, and every AXI channel is driven from a single control FSM.

---
 rtl/wishbone_to_axi4lite.sv | 223 ++++++++++++++++++++++
 tb/tb_wishbone_to_axi4lite.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_to_axi4lite.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | wishbone_to_axi4lite                                                       |
// | Wishbone classic slave to AXI4-Lite master bridge, one transaction at once.|
// | Optional response timeout: define WB2AXI_TIMEOUT_EN.                       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module wishbone_to_axi4lite #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic                    wb_we_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    wb_rty_o,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr_o,
  output logic                    axi_awvalid_o,
  input  logic                    axi_awready_i,
  output logic [DATA_WIDTH-1:0]   axi_wdata_o,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb_o,
  output logic                    axi_wvalid_o,
  input  logic                    axi_wready_i,
  input  logic [1:0]              axi_bresp_i,
  input  logic                    axi_bvalid_i,
  output logic                    axi_bready_o,
  output logic [ADDR_WIDTH-1:0]   axi_araddr_o,
  output logic                    axi_arvalid_o,
  input  logic                    axi_arready_i,
  input  logic [DATA_WIDTH-1:0]   axi_rdata_i,
  input  logic [1:0]              axi_rresp_i,
  input  logic                    axi_rvalid_i,
  output logic                    axi_rready_o
);

  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_DATA = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [DATA_WIDTH-1:0] r_dat;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [SW-1:0]         r_sel;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic                  r_abort;
  logic                  r_ack;
  logic                  r_err;

  logic w_req;
  logic w_active;
  logic w_live;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_timeout;
  logic w_to_done;
  logic w_fin_err;

  assign w_req    = wb_cyc_i & wb_stb_i;
  assign w_active = (r_state == S_WR_REQ) || (r_state == S_WR_RESP) ||
                    (r_state == S_RD_REQ) || (r_state == S_RD_DATA);
  // A request dropped at any point before completion loses its ack/err.
  assign w_live   = w_req & ~r_abort;
  assign w_aw_hs  = r_awvalid & axi_awready_i;
  assign w_w_hs   = r_wvalid & axi_wready_i;

`ifdef WB2AXI_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_cnt <= '0;
    end else if (w_active) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Fires on the edge at which the counter reaches TIMEOUT_CYCLES.
  assign w_timeout = w_active && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // resp >= 2'b10 is SLVERR/DECERR, i.e. resp[1].
  assign w_fin_err = w_timeout ? 1'b1 :
                     (r_state == S_WR_RESP) ? (axi_bresp_i >= 2'b10) :
                                              (axi_rresp_i >= 2'b10);
  assign w_to_done = w_timeout ||
                     ((r_state == S_WR_RESP) && axi_bvalid_i) ||
                     ((r_state == S_RD_DATA) && axi_rvalid_i);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= S_IDLE;
      r_adr     <= '0;
      r_dat     <= '0;
      r_sel     <= '0;
      r_rdata   <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_abort   <= 1'b0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      if (w_active && !w_req) begin
        r_abort <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_adr     <= wb_adr_i;
            r_dat     <= wb_dat_i;
            r_sel     <= wb_sel_i;
            r_abort   <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            if (wb_we_i) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= S_WR_REQ;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_RD_REQ;
            end
          end
        end
        S_WR_REQ: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
        end
        S_RD_REQ: begin
          if (r_arvalid && axi_arready_i) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (axi_rvalid_i && !w_timeout) begin
            r_rdata <= axi_rdata_i;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
      // Completion (response or timeout) overrides every branch above.
      if (w_to_done) begin
        r_awvalid <= 1'b0;
        r_wvalid  <= 1'b0;
        r_arvalid <= 1'b0;
        r_bready  <= 1'b0;
        r_rready  <= 1'b0;
        r_ack     <= w_live & ~w_fin_err;
        r_err     <= w_live & w_fin_err;
        r_state   <= S_DONE;
      end
    end
  end

  assign wb_dat_o      = r_rdata;
  assign wb_ack_o      = r_ack;
  assign wb_err_o      = r_err;
  assign wb_rty_o      = 1'b0;
  assign axi_awaddr_o  = r_adr;
  assign axi_awvalid_o = r_awvalid;
  assign axi_wdata_o   = r_dat;
  assign axi_wstrb_o   = r_sel;
  assign axi_wvalid_o  = r_wvalid;
  assign axi_bready_o  = r_bready;
  assign axi_araddr_o  = r_adr;
  assign axi_arvalid_o = r_arvalid;
  assign axi_rready_o  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_wishbone_to_axi4lite.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_wishbone_to_axi4lite                                                    |
// | Scoreboard bench: directed Wishbone requests against an AXI4-Lite slave.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_wishbone_to_axi4lite;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wb_adr = '0, wb_dat_i = '0;
  logic [3:0]  wb_sel = '0;
  logic        wb_we = 1'b0, wb_cyc = 1'b0, wb_stb = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack, wb_err, wb_rty;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bready, arvalid, arready, rready;
  logic [1:0]  bresp, rresp;
  logic        bvalid, rvalid;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  wishbone_to_axi4lite #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel), .wb_we_i(wb_we),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack), .wb_err_o(wb_err), .wb_rty_o(wb_rty),
    .axi_awaddr_o(awaddr), .axi_awvalid_o(awvalid), .axi_awready_i(awready),
    .axi_wdata_o(wdata), .axi_wstrb_o(wstrb), .axi_wvalid_o(wvalid), .axi_wready_i(wready),
    .axi_bresp_i(bresp), .axi_bvalid_i(bvalid), .axi_bready_o(bready),
    .axi_araddr_o(araddr), .axi_arvalid_o(arvalid), .axi_arready_i(arready),
    .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rvalid_i(rvalid), .axi_rready_o(rready)
  );

  // AXI4-Lite slave model with configurable ready delays and responses.
  int          cfg_aw_delay = 0, cfg_w_delay = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = '0;
  logic        cfg_ar_en = 1'b1;
  int          aw_cnt, w_cnt;
  logic        got_aw, got_w;

  assign awready = awvalid && (aw_cnt >= cfg_aw_delay);
  assign wready  = wvalid && (w_cnt >= cfg_w_delay);
  assign arready = arvalid && cfg_ar_en;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_cnt <= 0; w_cnt <= 0; got_aw <= 1'b0; got_w <= 1'b0;
      bvalid <= 1'b0; bresp <= 2'b00; rvalid <= 1'b0; rdata <= '0; rresp <= 2'b00;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      if (bvalid && bready) bvalid <= 1'b0;
      if ((got_aw || (awvalid && awready)) && (got_w || (wvalid && wready))) begin
        bvalid <= 1'b1; bresp <= cfg_bresp; got_aw <= 1'b0; got_w <= 1'b0;
      end else begin
        if (awvalid && awready) got_aw <= 1'b1;
        if (wvalid && wready) got_w <= 1'b1;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid <= 1'b1; rdata <= cfg_rdata; rresp <= cfg_rresp;
      end
    end
  end

  typedef struct packed {
    logic        err;
    logic [31:0] dat;
  } resp_t;

  resp_t       sb_q[$];
  logic [31:0] aw_q[$], ar_q[$];
  logic [35:0] w_q[$];
  int          n_checks = 0, n_fail = 0, n_resp = 0;
  int          aw_cyc = 0, w_cyc = 0, ar_cyc = 0, r_hs = 0;
  logic        prev_pulse = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every Wishbone response and checks AXI request fields.
  always @(negedge clk) begin
    resp_t e;
    if (wb_ack || wb_err) begin
      n_resp++;
      chk("pulse_single_cycle", {63'd0, prev_pulse}, 64'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_response", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("resp_ack_err", {62'd0, wb_ack, wb_err}, {62'd0, ~e.err, e.err});
        chk("wb_dat_o", {32'd0, wb_dat_o}, {32'd0, e.dat});
      end
    end
    prev_pulse = wb_ack || wb_err;
    if (awvalid) begin
      aw_cyc++;
      if (aw_q.size() == 0) chk("unexpected_awvalid", 64'd1, 64'd0);
      else begin
        chk("awaddr", {32'd0, awaddr}, {32'd0, aw_q[0]});
        if (awready) void'(aw_q.pop_front());
      end
    end
    if (wvalid) begin
      w_cyc++;
      if (w_q.size() == 0) chk("unexpected_wvalid", 64'd1, 64'd0);
      else begin
        chk("wstrb_wdata", {28'd0, wstrb, wdata}, {28'd0, w_q[0]});
        if (wready) void'(w_q.pop_front());
      end
    end
    if (arvalid) begin
      ar_cyc++;
      if (ar_q.size() == 0) chk("unexpected_arvalid", 64'd1, 64'd0);
      else begin
        chk("araddr", {32'd0, araddr}, {32'd0, ar_q[0]});
        if (arready) void'(ar_q.pop_front());
      end
    end
    if (rvalid && rready) r_hs++;
  end

  // Issue one request at a negedge; hold it until ack/err or the cycle budget expires.
  task automatic do_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic exp_err, input logic [31:0] exp_dat,
                        input int exp_lat, input logic zw);
    int   n;
    logic seen;
    resp_t e;
    if (we) begin
      aw_q.push_back(adr);
      w_q.push_back({sel, dat});
    end else begin
      ar_q.push_back(adr);
    end
    e.err = exp_err;
    e.dat = exp_dat;
    sb_q.push_back(e);
    wb_adr = adr; wb_dat_i = dat; wb_sel = sel; wb_we = we; wb_cyc = 1'b1; wb_stb = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      if (zw && n == 1) chk("valid_cycle1", we ? {62'd0, awvalid, wvalid} : {62'd0, arvalid, arvalid}, 64'd3);
      if (zw && n == 2) chk("ready_cycle2", {63'd0, we ? bready : rready}, 64'd1);
      if (wb_ack || wb_err) seen = 1'b1;
    end
    if (!seen) chk("response_timeout", 64'd0, 64'd1);
    else if (exp_lat > 0) chk("latency", 64'(n), 64'(exp_lat));
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int base_hs, base_resp;
    repeat (3) @(negedge clk);
    chk("reset_valids", {59'd0, awvalid, wvalid, bready, arvalid, rready}, 64'd0);
    chk("reset_wb", {29'd0, wb_ack, wb_err, wb_rty}, 64'd0);
    chk("reset_dat_o", {32'd0, wb_dat_o}, 64'd0);
    chk("reset_fields", {wstrb, awaddr, wdata[27:0]}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {59'd0, awvalid, wvalid, bready, arvalid, rready}, 64'd0);

    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, 3, 1'b1);
    cfg_rdata = 32'h12345678;
    do_req(1'b0, 32'h24, 32'h0, 4'h0, 1'b0, 32'h12345678, 3, 1'b1);

    cfg_aw_delay = 3; aw_cyc = 0; w_cyc = 0;
    do_req(1'b1, 32'h40, 32'hA5A50001, 4'h3, 1'b0, 32'h12345678, 6, 1'b0);
    chk("awvalid_cycles", 64'(aw_cyc), 64'd4);
    chk("wvalid_cycles", 64'(w_cyc), 64'd1);
    cfg_aw_delay = 0;

    cfg_rdata = 32'hCAFEF00D; cfg_rresp = 2'b10;
    do_req(1'b0, 32'h28, 32'h0, 4'h0, 1'b1, 32'hCAFEF00D, 3, 1'b1);
    cfg_rresp = 2'b00;
    cfg_bresp = 2'b11;
    do_req(1'b1, 32'h2C, 32'h0F0F0F0F, 4'h0, 1'b1, 32'hCAFEF00D, 3, 1'b1);
    cfg_bresp = 2'b00;

    // Master abort during RD_DATA: AXI completes, no Wishbone response.
    base_hs = r_hs; base_resp = n_resp; cfg_rdata = 32'h0BADF00D;
    ar_q.push_back(32'h30);
    wb_adr = 32'h30; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_rready_c2", {63'd0, rready}, 64'd1);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_r_handshake", 64'(r_hs - base_hs), 64'd1);
    chk("abort_no_response", 64'(n_resp - base_resp), 64'd0);
    chk("abort_idle", {61'd0, arvalid, rready, bready}, 64'd0);

    cfg_rdata = 32'h600DCAFE;
    do_req(1'b0, 32'h34, 32'h0, 4'h0, 1'b0, 32'h600DCAFE, 3, 1'b1);

    // Asynchronous reset mid-write clears outputs without a clock edge.
    cfg_aw_delay = 20; cfg_w_delay = 20;
    aw_q.push_back(32'h48); w_q.push_back({4'hF, 32'h55AA55AA});
    wb_adr = 32'h48; wb_dat_i = 32'h55AA55AA; wb_sel = 4'hF; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_valids", {62'd0, awvalid, wvalid}, 64'd0);
    chk("async_reset_dat_o", {32'd0, wb_dat_o}, 64'd0);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    aw_q.delete(); w_q.delete();
    cfg_aw_delay = 0; cfg_w_delay = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_req(1'b1, 32'h50, 32'h000000FF, 4'h1, 1'b0, 32'h0, 3, 1'b1);
    cfg_rdata = 32'h11223344;
    do_req(1'b0, 32'h44, 32'h0, 4'h0, 1'b0, 32'h11223344, 3, 1'b1);

`ifdef WB2AXI_TIMEOUT_EN
    cfg_ar_en = 1'b0; ar_cyc = 0; cfg_rdata = 32'h99999999;
    do_req(1'b0, 32'h60, 32'h0, 4'h0, 1'b1, 32'h11223344, 9, 1'b0);
    chk("timeout_arvalid_cycles", 64'(ar_cyc), 64'd8);
    chk("timeout_idle", {62'd0, arvalid, rready}, 64'd0);
    ar_q.delete();
    cfg_ar_en = 1'b1;
    do_req(1'b0, 32'h64, 32'h0, 4'h0, 1'b0, 32'h99999999, 3, 1'b1);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
